// File: rtl/pwm_servo_generator.sv
// 50 Hz servo PWM generator with preset/custom pulse width and optional slew.
// Pulse-width changes are taken only at period boundaries so Pwm_o never glitches.
module pwm_servo_generator #(
    parameter int period_p                    = 1000000,
    parameter int angle_0_clock_cycles_p      = 50000,
    parameter int angle_90_clock_cycles_p     = 75000,
    parameter int angle_180_clock_cycles_p    = 100000,
    parameter int step_p                      = 0,
    parameter int period_counter_length_p     = 20,
    parameter int duty_cycle_counter_length_p = 17,
    parameter int mux_sel_length_p            = 2
) (
    input  logic                                   Clk_i,
    input  logic                                   Reset_i,
    input  logic                                   Enable_i,
    input  logic [mux_sel_length_p-1:0]            Sel_i,
    input  logic [duty_cycle_counter_length_p-1:0] Duty_i,
    input  logic                                   Load_i,
    output logic                                   Load_Ack_o,
    output logic                                   Pwm_o,
    output logic                                   Period_Start_o,
    output logic [duty_cycle_counter_length_p-1:0] Duty_Active_o,
    output logic                                   Settled_o
);

    localparam int PW = period_counter_length_p;
    localparam int DW = duty_cycle_counter_length_p;
    localparam int MW = mux_sel_length_p;

    localparam logic [PW-1:0] LP_LAST = PW'(period_p - 1);
    localparam logic [DW-1:0] LP_A0   = DW'(angle_0_clock_cycles_p);
    localparam logic [DW-1:0] LP_A90  = DW'(angle_90_clock_cycles_p);
    localparam logic [DW-1:0] LP_A180 = DW'(angle_180_clock_cycles_p);
    localparam logic [DW-1:0] LP_STEP = DW'(step_p);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [PW-1:0] r_period_cnt;
    logic [DW-1:0] r_active;
    logic [DW-1:0] r_custom;
    logic          r_pwm;
    logic          r_period_start;
    logic          r_load_ack;

    logic          w_last;
    logic          w_update;
    logic          w_up;
    logic [DW-1:0] w_target;
    logic [DW-1:0] w_diff;
    logic [DW-1:0] w_next_active;
    logic [DW-1:0] w_duty_clamped;

    assign w_last   = (r_state == RUN) && (r_period_cnt == LP_LAST);
    assign w_update = Enable_i && ((r_state == IDLE) || w_last);

    always_comb begin
        w_target = r_custom;
        case (Sel_i)
            MW'(1):  w_target = LP_A0;
            MW'(2):  w_target = LP_A90;
            MW'(3):  w_target = LP_A180;
            default: w_target = r_custom;
        endcase
    end

    // Slew limiter: with step_p = 0 the target is taken in one boundary.
    always_comb begin
        w_up          = w_target > r_active;
        w_diff        = w_up ? (w_target - r_active) : (r_active - w_target);
        w_next_active = w_target;
        if (step_p != 0 && w_diff > LP_STEP) begin
            w_next_active = w_up ? (r_active + LP_STEP) : (r_active - LP_STEP);
        end
    end

    always_comb begin
        w_duty_clamped = Duty_i;
        if (Duty_i < LP_A0) begin
            w_duty_clamped = LP_A0;
        end else if (Duty_i > LP_A180) begin
            w_duty_clamped = LP_A180;
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_state      <= IDLE;
            r_period_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_period_cnt <= '0;
                    if (Enable_i) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_period_cnt <= '0;
                        if (!Enable_i) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_period_cnt <= r_period_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_period_cnt <= '0;
                end
            endcase
        end
    end

    // A load in the boundary cycle is seen by the update only next period.
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_active       <= LP_A90;
            r_custom       <= LP_A90;
            r_load_ack     <= 1'b0;
            r_period_start <= 1'b0;
            r_pwm          <= 1'b0;
        end else begin
            r_load_ack     <= Load_i;
            r_period_start <= w_update;
            r_pwm          <= (r_state == RUN) &&
                              (32'(r_period_cnt) < 32'(r_active));
            if (Load_i) begin
                r_custom <= w_duty_clamped;
            end
            if (w_update) begin
                r_active <= w_next_active;
            end
        end
    end

    assign Pwm_o          = r_pwm;
    assign Period_Start_o = r_period_start;
    assign Load_Ack_o     = r_load_ack;
    assign Duty_Active_o  = r_active;
    assign Settled_o      = (r_active == w_target);

endmodule

// File: doc/pwm_servo_generator.md
# pwm_servo_generator

Generates the 50 Hz control PWM for the MG995 servo: the transmit-side counterpart of the PWM monitor. It selects a pulse width from preset angles or a loaded custom value, limits the per-period change with an optional slew step, and applies all changes only at period boundaries. Pwm_o drives the servo pin and can be looped back to the monitor for self-check.

## Interface
- period_p, 1000000, PWM period in clock cycles (20 ms at 50 MHz)
- angle_0_clock_cycles_p, 50000, 1.0 ms pulse width
- angle_90_clock_cycles_p, 75000, 1.5 ms pulse width
- angle_180_clock_cycles_p, 100000, 2.0 ms pulse width
- step_p, 0, maximum change of the active pulse width per period, in cycles; 0 = no limit
- period_counter_length_p, 20, width of the period counter
- duty_cycle_counter_length_p, 17, width of all pulse-width values
- mux_sel_length_p, 2, width of Sel_i
- Clk_i  input  1  system clock
- Reset_i  input  1  asynchronous, active-low reset
- Enable_i  input  1  run request; sampled only while idle or at the last cycle of a period
- Sel_i  input  mux_sel_length_p  0 = custom register, 1 = 0°, 2 = 90°, 3 = 180°
- Duty_i  input  duty_cycle_counter_length_p  custom pulse width, in cycles
- Load_i  input  1  writes Duty_i into the custom register
- Load_Ack_o  output  1  one-cycle pulse one clock after Load_i
- Pwm_o  output  1  servo PWM, registered
- Period_Start_o  output  1  high in the first cycle of every period
- Duty_Active_o  output  duty_cycle_counter_length_p  pulse width in use for the current period
- Settled_o  output  1  high when Duty_Active_o equals the current target

## Operation
- States are IDLE and RUN. In IDLE, period_cnt is held at 0 and Pwm_o is 0.
- IDLE → RUN: on the first cycle with Enable_i=1. The next cycle is RUN with period_cnt=0, and a boundary update occurs on that transition.
- In RUN, period_cnt increments every cycle.
- At period_cnt = period_p-1 with Enable_i=1: period_cnt wraps to 0 and a boundary update occurs.
- At period_cnt = period_p-1 with Enable_i=0: go to IDLE. Periods are never truncated.
- Boundary update:
  - The target is custom_r when Sel_i=0; otherwise it is the selected preset. Sel_i is sampled in the update cycle only.
  - If step_p=0 or |target − active| ≤ step_p, active becomes target.
  - Otherwise, active moves toward target by exactly step_p.
- Custom register: when Load_i=1, custom_r gets Duty_i clamped to [angle_0, angle_180].
- If Load_i and a boundary update fall in the same cycle, the update uses the old custom_r. The new value applies from the next boundary.
- Pwm_o is registered: Pwm_o(t+1) = (state=RUN) and (period_cnt(t) < active). It is therefore high for exactly active cycles per period, rising one clock after Period_Start_o.
- Settled_o is combinational: active equals the target currently selected by Sel_i/custom_r.
- Reset values (immediate, including mid-period):
  - state = IDLE, period_cnt = 0
  - Pwm_o = 0, Period_Start_o = 0, Load_Ack_o = 0
  - active = angle_90, custom_r = angle_90

## Timing
- Latency from Enable_i rising in IDLE to the Period_Start_o pulse is 1 cycle.
- The Pwm_o rising edge follows Period_Start_o by 1 cycle.
- A Sel_i or custom_r change takes effect from the next period start, never mid-period.
- With step_p>0, moving from angle_0 to angle_180 takes ceil((angle_180 − angle_0)/step_p) periods.
- Pwm_o is glitch-free because it is driven directly from a flop.

## Test plan
Small parameters throughout: period_p=100, angle_0=10, angle_90=15, angle_180=20.

- Reset, then Enable_i=1 with Sel_i=2 and step_p=0 → Period_Start_o every 100 cycles; Pwm_o high for exactly 15 cycles per period, rising 1 cycle after Period_Start_o.
- Sel_i switched 2→3 at period_cnt=50 → the current period keeps a 15-cycle pulse; the next period has 20.
- step_p=2, Sel_i 1→3 after settling at 10 → successive pulse widths 12, 14, 16, 18, 20; Settled_o goes high only in the 20 period.
- Sel_i=0 with Load_i and Duty_i = 5, then 30, then 17 → Load_Ack_o follows each load; applied widths are 10, 20, 17.
- Enable_i dropped at period_cnt=3 → the period completes with the full pulse; the FSM then goes to IDLE and Pwm_o stays 0.
- Reset_i asserted mid-pulse → Pwm_o=0 immediately and Duty_Active_o=15; after reset release, re-enable restarts cleanly at period_cnt=0.
